// File: rtl/pc_gen.sv
// Fetch PC register with exception/ERET/redirect loads, stall hold and a direct-mapped BTB.
// Next PC registered each edge (one cycle); BTB lookup is combinational on pc, stall holds pc.
module pc_gen #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0]   EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter int                 BTB_DEPTH  = 8,
    parameter bit                 BTB_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken,
    output logic [WIDTH-1:0] pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    output logic             redirected
);
    localparam int               IDX        = $clog2(BTB_DEPTH);
    localparam int               TAGW       = WIDTH - IDX - 2;
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [BTB_DEPTH-1:0] btb_vld;
    logic [TAGW-1:0]      btb_tag [BTB_DEPTH];
    logic [WIDTH-1:0]     btb_tgt [BTB_DEPTH];

    logic [IDX-1:0]   rd_idx;
    logic [TAGW-1:0]  rd_tag;
    logic [IDX-1:0]   wr_idx;
    logic [TAGW-1:0]  wr_tag;
    logic [WIDTH-1:0] pc_next;
    logic             load;
    logic [3:0]       unused_bits;

    assign rd_idx      = pc[IDX+1:2];
    assign rd_tag      = pc[WIDTH-1:IDX+2];
    assign wr_idx      = upd_pc[IDX+1:2];
    assign wr_tag      = upd_pc[WIDTH-1:IDX+2];
    assign unused_bits = {pc[1:0], upd_pc[1:0]};

    assign pred_taken  = BTB_EN && btb_vld[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign pred_target = pred_taken ? btb_tgt[rd_idx] : '0;

    always_comb begin
        pc_next = pc + WIDTH'(4);
        load    = 1'b0;
        if (ex_req) begin
            pc_next = EXC_VECTOR;
            load    = 1'b1;
        end else if (eret) begin
            pc_next = epc & ALIGN_MASK;
            load    = 1'b1;
        end else if (redirect_valid) begin
            pc_next = redirect_pc & ALIGN_MASK;
            load    = 1'b1;
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            redirected <= 1'b0;
        end else begin
            pc         <= pc_next;
            redirected <= load;
        end
    end

    // A not-taken update only evicts the entry if it belongs to the same branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_vld <= '0;
        end else if (BTB_EN && upd_valid) begin
            if (upd_taken) begin
                btb_vld[wr_idx] <= 1'b1;
            end else if (btb_tag[wr_idx] == wr_tag) begin
                btb_vld[wr_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (BTB_EN && upd_valid && upd_taken) begin
            btb_tag[wr_idx] <= wr_tag;
            btb_tgt[wr_idx] <= upd_target & ALIGN_MASK;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: address-level reference model for a predicting and a non-predicting instance.
module tb_pc_gen;
    localparam logic [31:0] RST  = 32'h0000_3000;
    localparam logic [31:0] EXC  = 32'h0000_4180;
    localparam logic [31:0] MASK = 32'hFFFF_FFFC;

    logic clk = 1'b0, reset = 1'b0, stall = 1'b0, ex_req = 1'b0, eret = 1'b0;
    logic redirect_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [31:0] epc = '0, redirect_pc = '0, upd_pc = '0, upd_target = '0;
    logic [31:0] pc0, pc1, tgt0, tgt1;
    logic        pt0, pt1, rd0, rd1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pc_gen #(.BTB_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_req(ex_req), .eret(eret), .epc(epc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc(pc0), .pred_taken(pt0), .pred_target(tgt0), .redirected(rd0));

    pc_gen #(.BTB_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .stall(stall), .ex_req(ex_req), .eret(eret), .epc(epc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc(pc1), .pred_taken(pt1), .pred_target(tgt1), .redirected(rd1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each BTB slot remembers which branch address it holds;
    // a hit means the fetch address is exactly that branch. Index 1 is the BTB-disabled instance.
    bit          m_val [2][8];
    logic [31:0] m_bpc [2][8];
    logic [31:0] m_tgt [2][8];
    logic [31:0] m_pc  [2];
    bit          m_red [2];

    function automatic int slot(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd8);
    endfunction

    function automatic bit m_hit(input int k);
        int s;
        s = slot(m_pc[k]);
        return (k == 0) && m_val[k][s] && (m_bpc[k][s] == m_pc[k]);
    endfunction

    function automatic logic [31:0] m_ptgt(input int k);
        return m_hit(k) ? m_tgt[k][slot(m_pc[k])] : 32'h0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_pc[k]  = RST;
                m_red[k] = 1'b0;
                for (int s = 0; s < 8; s++) m_val[k][s] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] nxt;
                logic [31:0] pa;
                int          s;
                if (ex_req)              nxt = EXC;
                else if (eret)           nxt = epc & MASK;
                else if (redirect_valid) nxt = redirect_pc & MASK;
                else if (stall)          nxt = m_pc[k];
                else if (m_hit(k))       nxt = m_tgt[k][slot(m_pc[k])];
                else                     nxt = m_pc[k] + 32'd4;
                if (upd_valid && k == 0) begin
                    s  = slot(upd_pc);
                    pa = upd_pc & MASK;
                    if (upd_taken) begin
                        m_val[k][s] = 1'b1;
                        m_bpc[k][s] = pa;
                        m_tgt[k][s] = upd_target & MASK;
                    end else if (m_val[k][s] && m_bpc[k][s] == pa) begin
                        m_val[k][s] = 1'b0;
                    end
                end
                m_red[k] = ex_req || eret || redirect_valid;
                m_pc[k]  = nxt;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_pc",   pc0,        m_pc[0]);
        chk("model_red",  32'(rd0),   32'(m_red[0]));
        chk("model_pt",   32'(pt0),   32'(m_hit(0)));
        chk("model_tgt",  tgt0,       m_ptgt(0));
        chk("model_nb_pc",  pc1,      m_pc[1]);
        chk("model_nb_red", 32'(rd1), 32'(m_red[1]));
        chk("model_nb_pt",  32'(pt1), 32'h0);
        chk("model_nb_tgt", tgt1,     32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Scenario 1: asynchronous reset mid-run, then sequential fetch
        #2 reset = 1'b0;
        #1 chk("rst_async_pc", pc0, 32'h3000);
        chk("rst_async_red", 32'(rd0), 32'h0);
        tick();
        reset = 1'b1;
        tick(); chk("seq_3004", pc0, 32'h3004);
        tick(); chk("seq_3008", pc0, 32'h3008);
        tick(); chk("seq_300c", pc0, 32'h300C);
        chk("seq_red", 32'(rd0), 32'h0);
        chk("seq_pt",  32'(pt0), 32'h0);
        tick(); chk("seq_3010", pc0, 32'h3010);

        // Scenario 2: priority ordering
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3100;
        eret = 1'b1; epc = 32'h3200; ex_req = 1'b1;
        tick(); chk("prio_exc", pc0, 32'h4180); chk("prio_exc_red", 32'(rd0), 32'h1);
        ex_req = 1'b0;
        tick(); chk("prio_eret", pc0, 32'h3200); chk("prio_eret_red", 32'(rd0), 32'h1);
        eret = 1'b0;
        tick(); chk("prio_redir", pc0, 32'h3100);
        redirect_valid = 1'b0;
        tick(); chk("prio_stall", pc0, 32'h3100); chk("prio_stall_red", 32'(rd0), 32'h0);
        tick(); chk("prio_stall2", pc0, 32'h3100);
        stall = 1'b0;

        // Scenario 3: train then predict
        upd_valid = 1'b1; upd_pc = 32'h3020; upd_target = 32'h3400; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        do_redirect(32'h3020);
        chk("btb_pt", 32'(pt0), 32'h1); chk("btb_tgt", tgt0, 32'h3400);
        chk("nb_pt", 32'(pt1), 32'h0);
        tick(); chk("btb_follow", pc0, 32'h3400); chk("btb_follow_red", 32'(rd0), 32'h0);

        // Scenario 4: alias not-taken leaves entry; own not-taken clears it
        upd_valid = 1'b1; upd_pc = 32'h3040; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        do_redirect(32'h3020);
        chk("alias_keep_pt", 32'(pt0), 32'h1);
        upd_valid = 1'b1; upd_pc = 32'h3020; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        do_redirect(32'h3020);
        chk("clear_pt", 32'(pt0), 32'h0);
        tick(); chk("clear_next", pc0, 32'h3024);

        // Scenario 5: same-edge update sees old contents; misaligned target is masked
        do_redirect(32'h3020);
        chk("same_pre_pt", 32'(pt0), 32'h0);
        upd_valid = 1'b1; upd_pc = 32'h3020; upd_target = 32'h3402; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        chk("same_next", pc0, 32'h3024);
        do_redirect(32'h3020);
        chk("same_later_pt", 32'(pt0), 32'h1); chk("same_later_tgt", tgt0, 32'h3400);
        tick(); chk("same_later_follow", pc0, 32'h3400);

        // Scenario 6: alignment and wrap
        do_redirect(32'hFFFF_FFFE);
        chk("wrap_align", pc0, 32'hFFFF_FFFC);
        tick(); chk("wrap_zero", pc0, 32'h0000_0000);
        eret = 1'b1; epc = 32'h0000_5007;
        tick(); eret = 1'b0;
        chk("eret_align", pc0, 32'h0000_5004);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-stage program-counter generator for the pipelined MIPS core.
- Supersedes the purely combinational next-PC select with:
  - a registered PC,
  - stall hold,
  - exception entry and ERET return,
  - decode-stage redirect,
  - a direct-mapped branch target buffer (BTB) that predicts taken branches and jumps at fetch.
- Sits between the hazard/CP0 units and instruction memory.
- Branch/jump targets are computed in decode and arrive here as redirect or BTB update requests.

Parameters:
- WIDTH, 32, address width in bits (≥8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception entry.
- BTB_DEPTH, 8, number of BTB entries (power of two, ≥2).
- BTB_EN, 1, 0 disables prediction (pred_taken tied 0, BTB storage unused).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC (hazard unit).
- ex_req  in  1  exception entry request.
- eret  in  1  return from exception.
- epc  in  WIDTH  return address for eret.
- redirect_valid  in  1  decode resolved a mispredict or unpredicted jump.
- redirect_pc  in  WIDTH  correct next PC for redirect.
- upd_valid  in  1  BTB update strobe from decode.
- upd_pc  in  WIDTH  PC of the resolved branch/jump.
- upd_target  in  WIDTH  resolved target.
- upd_taken  in  1  branch was taken.
- pc  out  WIDTH  current fetch PC.
- pred_taken  out  1  BTB hit for current pc.
- pred_target  out  WIDTH  predicted target (valid when pred_taken).
- redirected  out  1  current pc was loaded by ex_req/eret/redirect.

Behaviour:
- **Reset** (reset=0, asynchronous, immediate):
  - pc=RESET_PC, redirected=0, all BTB valid bits cleared.
  - Mid-operation reset discards any pending update.
- **Next-PC priority** at each rising edge, highest first:
  1. ex_req → EXC_VECTOR
  2. eret → epc
  3. redirect_valid → redirect_pc
  4. stall → hold pc
  5. pred_taken → pred_target
  6. otherwise pc+4
- ex_req, eret and redirect override stall.
- redirected is registered: 1 in the cycle after a priority-1/2/3 load, else 0. Stall does not hold it high.
- **Alignment:** pc[1:0] always 00. Incoming epc, redirect_pc and upd_target have bits [1:0] forced to 0 before use.
- **Arithmetic:** pc+4 is modulo 2^WIDTH; max aligned address wraps to 0.
- **BTB geometry:**
  - IDX = log2(BTB_DEPTH).
  - index = addr[IDX+1:2], tag = addr[WIDTH-1:IDX+2].
  - Each entry: valid, tag, target.
- **BTB lookup:** combinational on pc. pred_taken = BTB_EN & valid & tag match. pred_target = entry target, or 0 when not hit.
- **BTB update** on a clock edge with upd_valid=1, indexed by upd_pc:
  - upd_taken=1: write valid=1, tag, target (replaces any occupant).
  - upd_taken=0: clear valid only if the stored tag matches; otherwise no change.
- Updates are written at the edge. A same-cycle lookup of the same index returns pre-update contents. Update proceeds regardless of stall/ex_req/eret/redirect.
- With BTB_EN=0, updates are ignored and pred_taken=0.
- No other state. The block holds no delay-slot logic; decode supplies correct redirect_pc.

Test Plan:
1. **Reset and sequential fetch:** assert reset low mid-run, release, no other inputs for 3 cycles.
   - Required: pc=0x3000 immediately on assert.
   - Then 0x3004, 0x3008, 0x300C; redirected=0; pred_taken=0.
2. **Priority:** at pc=0x3010, assert stall+redirect_valid(0x3100)+eret(epc=0x3200)+ex_req together.
   - Required: next pc=0x4180, redirected=1 for one cycle.
   - Repeat without ex_req → 0x3200; then only stall+redirect → 0x3100; then only stall → pc holds.
3. **BTB train/predict** (BTB_DEPTH=8): upd_valid, upd_pc=0x3020, upd_target=0x3400, upd_taken=1; then redirect to 0x3020.
   - Required: pred_taken=1, pred_target=0x3400, next pc=0x3400.
4. **BTB alias/clear:**
   - Train 0x3020 as in scenario 3, then update upd_pc=0x3040 (same index, different tag), upd_taken=0 → entry for 0x3020 unchanged.
   - Then update 0x3020 with upd_taken=0 → fetch at 0x3020 gives pred_taken=0, next pc 0x3024.
5. **Same-cycle update vs lookup:** while pc=0x3020 with an empty entry, apply an update for 0x3020 taken.
   - Required: pred_taken=0 this cycle, next pc=0x3024.
   - Returning to 0x3020 later gives a hit.
6. **Wrap and alignment:**
   - redirect_pc=0xFFFF_FFFE → pc=0xFFFF_FFFC, then 0x0000_0000.
   - With BTB_EN=0, a trained update never produces pred_taken=1.
